// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM states, slave-select
// codes and EEPROM opcode prefixes used by requesters that build SPI words.
package spi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] SS_NONE = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;
  localparam logic [2:0] SS_TRIG = 3'b111;

  localparam logic [1:0] EEP_WR = 2'b01;
  localparam logic [1:0] EEP_RD = 2'b00;

  // A slave select of all-zero addresses nothing, so a request carrying it is refused.
  function automatic logic ss_legal(input logic [2:0] sel);
    return sel != SS_NONE;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin picker: the first set request found when scanning
// upward from ptr (wrapping at NUM_REQ) wins.
module rr_arbiter
  import spi_bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0]      winner_idx,
  output logic               any
);

  int pos;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any && req[pos]) begin
        any         = 1'b1;
        winner[pos] = 1'b1;
        winner_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin grant and
// an optional lock that keeps ss and ownership across multi-word transactions.
//
// state  | meaning
// IDLE   | bus free, ss=000; picks next winner round-robin from rr_ptr
// LAUNCH | one cycle: wrt_SPI strobe with the latched word and ss
// BUSY   | waiting for SPI_done; done pulses to the owner next cycle
// HOLD   | locked owner keeps ss/gnt between words; hold_cnt bounds the wait
module spi_bus_arbiter
  import spi_bus_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int HOLD_MAX = 255,
  parameter int HCW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      lock,
  input  logic [3*NUM_REQ-1:0]    req_ss,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic                    SPI_done,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic [15:0]             SPI_data,
  output logic [2:0]              ss,
  output logic                    wrt_SPI
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_nxt;
  logic [IW-1:0]      owner, owner_nxt;
  logic [HCW-1:0]     hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               err_nxt, wrt_nxt;
  logic [15:0]        data_nxt;
  logic [2:0]         ss_nxt;
  logic               rel;

  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [2:0]         win_ss;
  logic [15:0]        win_data;
  logic [15:0]        own_data;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    int n;
    n = int'(p) + 1;
    if (n >= NUM_REQ) n = 0;
    return IW'(n);
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (req),
    .ptr        (rr_ptr),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  assign win_ss   = req_ss[int'(win_idx)*3 +: 3];
  assign win_data = req_data[int'(win_idx)*16 +: 16];
  assign own_data = req_data[int'(owner)*16 +: 16];

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    wrt_nxt   = 1'b0;
    data_nxt  = SPI_data;
    ss_nxt    = ss;
    rel       = 1'b0;

    case (state)
      IDLE: begin
        gnt_nxt = '0;
        ss_nxt  = SS_NONE;
        if (win_any) begin
          owner_nxt = win_idx;
          if (ss_legal(win_ss)) begin
            state_nxt = LAUNCH;
            gnt_nxt   = win_oh;
            ss_nxt    = win_ss;
            data_nxt  = win_data;
            wrt_nxt   = 1'b1;
          end else begin
            // Refused request still completes so the requester can drop req.
            done_nxt = win_oh;
            err_nxt  = 1'b1;
            rr_nxt   = next_ptr(win_idx);
          end
        end
      end

      LAUNCH: state_nxt = BUSY;

      BUSY: begin
        if (SPI_done) begin
          done_nxt = gnt;
          if (lock[owner]) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end else begin
            rel = 1'b1;
          end
        end
      end

      HOLD: begin
        hold_nxt = hold_cnt + 1'b1;
        if (req[owner]) begin
          // Next word of the locked transaction keeps the original ss.
          state_nxt = LAUNCH;
          data_nxt  = own_data;
          wrt_nxt   = 1'b1;
        end else if (!lock[owner]) begin
          rel = 1'b1;
        end else if (hold_cnt == HCW'(HOLD_MAX)) begin
          rel     = 1'b1;
          err_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (rel) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      ss_nxt    = SS_NONE;
      hold_nxt  = '0;
      rr_nxt    = next_ptr(owner);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      wrt_SPI  <= 1'b0;
      SPI_data <= 16'h0000;
      ss       <= SS_NONE;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      wrt_SPI  <= wrt_nxt;
      SPI_data <= data_nxt;
      ss       <= ss_nxt;
    end
  end

endmodule
